// File: rtl/sdram_responder.sv
// sdram_responder: single-data-rate SDRAM device emulator (responder end of the
// controller pin interface). Decodes pin commands, tracks per-bank open rows,
// returns read data after the programmed CAS latency from a small on-chip array,
// and raises sticky protocol/timing violation flags.
// Ports: clk, rst_n (sync, active-low); i_clock_enable, i_cs_n, i_ras_n,
//   i_cas_n, i_we_n, i_bank_addr, i_addr, i_data_mask, i_dq_in (command/data in);
//   o_dq_out, o_dq_oe (read return); o_init_done, o_cas_latency, o_err_flags.
// Optional: define SDRAM_RESP_STATS_EN to add o_rd_count, o_wr_count,
//   o_ref_count (16-bit saturating counters of executed READ/WRITE/REF).
module sdram_responder #(
    parameter int ROW_WIDTH  = 13,
    parameter int COL_WIDTH  = 10,
    parameter int BANK_WIDTH = 2,
    parameter int ROW_USED   = 4,
    parameter int COL_USED   = 6,
    parameter int T_RCD      = 2,
    parameter int T_RP       = 2,
    parameter int T_RFC      = 8,
    localparam int ADDR_WIDTH = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clock_enable,
    input  logic                  i_cs_n,
    input  logic                  i_ras_n,
    input  logic                  i_cas_n,
    input  logic                  i_we_n,
    input  logic [BANK_WIDTH-1:0] i_bank_addr,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_data_mask,
    input  logic [7:0]            i_dq_in,
    output logic [7:0]            o_dq_out,
    output logic                  o_dq_oe,
    output logic                  o_init_done,
    output logic [1:0]            o_cas_latency,
    output logic [3:0]            o_err_flags
`ifdef SDRAM_RESP_STATS_EN
    ,
    output logic [15:0]           o_rd_count,
    output logic [15:0]           o_wr_count,
    output logic [15:0]           o_ref_count
`endif
);

    localparam int NBANK     = 1 << BANK_WIDTH;
    localparam int IDX_W     = BANK_WIDTH + ROW_USED + COL_USED;
    localparam int MEM_DEPTH = 1 << IDX_W;

    // Timers count from 0 at the arming edge, so a command k edges later
    // sees the value k-1.
    localparam logic [3:0] RCD_MIN = 4'(T_RCD - 1);
    localparam logic [3:0] RP_MIN  = 4'(T_RP - 1);
    localparam logic [3:0] RFC_MIN = 4'(T_RFC - 1);

    logic [7:0]           r_mem [MEM_DEPTH];
    logic [NBANK-1:0]     r_open;
    logic [ROW_WIDTH-1:0] r_row [NBANK];
    logic [3:0]           r_btimer [NBANK];
    logic [3:0]           r_rtimer;
    logic [1:0]           r_cl;
    logic                 r_init;
    logic [3:0]           r_err;
    logic                 r_s1_v;
    logic [7:0]           r_s1_d;
    logic                 r_s2_v;
    logic [7:0]           r_s2_d;
    logic [7:0]           r_dq_out;
    logic                 r_dq_oe;

    logic [3:0]       w_cmd;
    logic             w_act, w_rd, w_wr, w_pre, w_ref, w_mrs, w_any;
    logic             w_ignored, w_open, w_a10;
    logic             w_act_ok, w_rd_ok, w_wr_ok, w_ref_ok, w_rw_closed;
    logic             w_act_early, w_rw_early, w_rfc_bad, w_mrs_bad, w_cl_ok;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_rd_data;
    logic [3:0]       w_err_set;

    // CKE low turns the pins into a NOP.
    assign w_cmd = i_clock_enable ? {i_cs_n, i_ras_n, i_cas_n, i_we_n} : 4'b0111;
    assign w_act = (w_cmd == 4'b0011);
    assign w_rd  = (w_cmd == 4'b0101);
    assign w_wr  = (w_cmd == 4'b0100);
    assign w_pre = (w_cmd == 4'b0010);
    assign w_ref = (w_cmd == 4'b0001);
    assign w_mrs = (w_cmd == 4'b0000);
    assign w_any = w_act | w_rd | w_wr | w_pre | w_ref | w_mrs;

    assign w_ignored   = (w_act | w_rd | w_wr | w_ref) & ~r_init;
    assign w_open      = r_open[i_bank_addr];
    assign w_a10       = i_addr[10];
    assign w_act_ok    = w_act & r_init;
    assign w_ref_ok    = w_ref & r_init;
    assign w_rd_ok     = w_rd & r_init & w_open;
    assign w_wr_ok     = w_wr & r_init & w_open;
    assign w_rw_closed = (w_rd | w_wr) & r_init & ~w_open;

    assign w_act_early = w_act_ok & (r_btimer[i_bank_addr] < RP_MIN);
    assign w_rw_early  = (w_rd_ok | w_wr_ok) & (r_btimer[i_bank_addr] < RCD_MIN);
    assign w_rfc_bad   = w_any & ~w_ignored & (r_rtimer < RFC_MIN);
    assign w_cl_ok     = (i_addr[6:4] == 3'd2) | (i_addr[6:4] == 3'd3);
    assign w_mrs_bad   = w_mrs & (~w_cl_ok | (i_addr[2:0] != 3'd0));

    assign w_err_set = {
        w_ignored,
        w_act_early | w_rw_early | w_rfc_bad | w_mrs_bad,
        (w_act_ok & w_open) | (w_ref_ok & (|r_open)),
        w_rw_closed
    };

    // Higher row/column bits alias onto the stored subset.
    assign w_idx = {i_bank_addr, r_row[i_bank_addr][ROW_USED-1:0],
                    i_addr[COL_USED-1:0]};
    assign w_rd_data = r_mem[w_idx];

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_ok && !i_data_mask) begin
            r_mem[w_idx] <= i_dq_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_open   <= '0;
            r_rtimer <= 4'hF;
            r_cl     <= 2'd3;
            r_init   <= 1'b0;
            r_err    <= '0;
            r_s1_v   <= 1'b0;
            r_s1_d   <= '0;
            r_s2_v   <= 1'b0;
            r_s2_d   <= '0;
            r_dq_out <= '0;
            r_dq_oe  <= 1'b0;
            for (int b = 0; b < NBANK; b++) begin
                r_row[b]    <= '0;
                r_btimer[b] <= 4'hF;
            end
        end else begin
            r_err <= r_err | w_err_set;

            for (int b = 0; b < NBANK; b++) begin
                if (r_btimer[b] != 4'hF) r_btimer[b] <= r_btimer[b] + 4'd1;
            end
            if (r_rtimer != 4'hF) r_rtimer <= r_rtimer + 4'd1;

            if (w_act_ok) begin
                r_open[i_bank_addr]   <= 1'b1;
                r_row[i_bank_addr]    <= i_addr[ROW_WIDTH-1:0];
                r_btimer[i_bank_addr] <= '0;
            end
            if (w_pre) begin
                if (w_a10) begin
                    r_open <= '0;
                    for (int b = 0; b < NBANK; b++) r_btimer[b] <= '0;
                end else begin
                    r_open[i_bank_addr]   <= 1'b0;
                    r_btimer[i_bank_addr] <= '0;
                end
            end
            if ((w_rd_ok | w_wr_ok) && w_a10) begin
                r_open[i_bank_addr]   <= 1'b0;
                r_btimer[i_bank_addr] <= '0;
            end
            if (w_ref_ok) r_rtimer <= '0;

            if (w_mrs) begin
                r_init <= 1'b1;
                if (w_cl_ok) r_cl <= i_addr[5:4];
            end

            // CL3 reads enter one stage earlier than CL2 reads, so the
            // latency is fixed per read at issue time.
            r_s2_v <= r_s1_v;
            r_s2_d <= r_s1_d;
            r_s1_v <= 1'b0;
            if (w_rd_ok) begin
                if (r_cl == 2'd2) begin
                    r_s2_v <= 1'b1;
                    r_s2_d <= w_rd_data;
                end else begin
                    r_s1_v <= 1'b1;
                    r_s1_d <= w_rd_data;
                end
            end
            r_dq_oe  <= r_s2_v;
            r_dq_out <= r_s2_v ? r_s2_d : 8'd0;
        end
    end

    assign o_dq_out      = r_dq_out;
    assign o_dq_oe       = r_dq_oe;
    assign o_init_done   = r_init;
    assign o_cas_latency = r_cl;
    assign o_err_flags   = r_err;

`ifdef SDRAM_RESP_STATS_EN
    logic [15:0] r_rd_count, r_wr_count, r_ref_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_count  <= '0;
            r_wr_count  <= '0;
            r_ref_count <= '0;
        end else begin
            if (w_rd_ok && r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
            if (w_wr_ok && r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
            if (w_ref_ok && r_ref_count != 16'hFFFF) r_ref_count <= r_ref_count + 16'd1;
        end
    end

    assign o_rd_count  = r_rd_count;
    assign o_wr_count  = r_wr_count;
    assign o_ref_count = r_ref_count;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: scoreboard bench for sdram_responder. Expected read bytes
// and their return cycle are queued at READ issue and matched when dq_oe rises.
module tb_sdram_responder;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cke;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [1:0]  bank;
    logic [12:0] addr;
    logic        dm;
    logic [7:0]  dq_in;
    logic [7:0]  dq_out;
    logic        dq_oe;
    logic        init_done;
    logic [1:0]  cas_lat;
    logic [3:0]  err;
`ifdef SDRAM_RESP_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, ref_cnt;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tb_cl = 3;
    int   n_checks = 0;
    int   n_pass = 0;

    sdram_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_clock_enable (cke),
        .i_cs_n         (cs_n),
        .i_ras_n        (ras_n),
        .i_cas_n        (cas_n),
        .i_we_n         (we_n),
        .i_bank_addr    (bank),
        .i_addr         (addr),
        .i_data_mask    (dm),
        .i_dq_in        (dq_in),
        .o_dq_out       (dq_out),
        .o_dq_oe        (dq_oe),
        .o_init_done    (init_done),
        .o_cas_latency  (cas_lat),
        .o_err_flags    (err)
`ifdef SDRAM_RESP_STATS_EN
        ,
        .o_rd_count     (rd_cnt),
        .o_wr_count     (wr_cnt),
        .o_ref_count    (ref_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Scoreboard: every dq_oe cycle must match the oldest queued read.
    always @(negedge clk) begin
        if (dq_oe === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_oe", {31'd0, dq_oe}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rd_cycle", cyc, e.cyc);
                check("rd_data", {24'd0, dq_out}, {24'd0, e.data});
            end
        end
    end

    task automatic issue(input logic [3:0] c, input logic [1:0] b,
                         input logic [12:0] a, input logic m,
                         input logic [7:0] d);
        {cs_n, ras_n, cas_n, we_n} = c;
        bank  = b;
        addr  = a;
        dm    = m;
        dq_in = d;
        @(posedge clk);
        #1;
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
        dm = 1'b0;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mrs(input logic [12:0] a);
        logic [2:0] f;
        issue(C_MRS, 2'd0, a, 1'b0, 8'd0);
        f = a[6:4];
        if (f == 3'd2) tb_cl = 2;
        else if (f == 3'd3) tb_cl = 3;
    endtask

    task automatic rd(input logic [1:0] b, input logic [12:0] a,
                      input logic [7:0] exp);
        exp_t e;
        issue(C_RD, b, a, 1'b0, 8'd0);
        e.cyc  = cyc + tb_cl - 1;
        e.data = exp;
        q.push_back(e);
    endtask

    task automatic wr(input logic [1:0] b, input logic [12:0] a,
                      input logic m, input logic [7:0] d);
        issue(C_WR, b, a, m, d);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        nop(n);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        cke   = 1'b1;
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
        bank  = '0;
        addr  = '0;
        dm    = 1'b0;
        dq_in = '0;
        tb_cl = 3;
        nop(3);
        check("rst_oe", {31'd0, dq_oe}, 32'd0);
        check("rst_dq", {24'd0, dq_out}, 32'd0);
        check("rst_init", {31'd0, init_done}, 32'd0);
        check("rst_cl", {30'd0, cas_lat}, 32'd3);
        check("rst_err", {28'd0, err}, 32'd0);
        rst_n = 1'b1;

        // Conventional init order: REFs issued before the mode load are
        // ignored and flagged.
        issue(C_PRE, 2'd0, 13'h400, 1'b0, 8'd0);
        issue(C_REF, 2'd0, 13'h000, 1'b0, 8'd0);
        nop(8);
        issue(C_REF, 2'd0, 13'h000, 1'b0, 8'd0);
        nop(8);
        mrs(13'h230);
        check("init_done", {31'd0, init_done}, 32'd1);
        check("init_cl", {30'd0, cas_lat}, 32'd3);
        check("init_err", {28'd0, err}, 32'd8);

        do_reset(2);
        check("rst2_init", {31'd0, init_done}, 32'd0);
        check("rst2_err", {28'd0, err}, 32'd0);
        mrs(13'h230);
        issue(C_REF, 2'd0, 13'h000, 1'b0, 8'd0);
        nop(8);
        check("clean_init_err", {28'd0, err}, 32'd0);
        check("clean_init_done", {31'd0, init_done}, 32'd1);

        // Write with auto-precharge, reopen after T_RP, read back at CL3.
        issue(C_ACT, 2'd1, 13'h005, 1'b0, 8'd0);
        nop(2);
        wr(2'd1, 13'h412, 1'b0, 8'hA5);
        nop(1);
        issue(C_ACT, 2'd1, 13'h005, 1'b0, 8'd0);
        nop(2);
        rd(2'd1, 13'h012, 8'hA5);
        nop(4);
        check("wr_rd_err", {28'd0, err}, 32'd0);

        // Masked write leaves the old byte.
        wr(2'd1, 13'h020, 1'b0, 8'h3C);
        wr(2'd1, 13'h020, 1'b1, 8'hFF);
        rd(2'd1, 13'h020, 8'h3C);
        rd(2'd1, 13'h012, 8'hA5);
        nop(4);

        // CL2 with back-to-back reads.
        mrs(13'h220);
        check("cl2", {30'd0, cas_lat}, 32'd2);
        wr(2'd1, 13'h000, 1'b0, 8'h11);
        wr(2'd1, 13'h001, 1'b0, 8'h22);
        wr(2'd1, 13'h002, 1'b0, 8'h33);
        rd(2'd1, 13'h000, 8'h11);
        rd(2'd1, 13'h001, 8'h22);
        rd(2'd1, 13'h002, 8'h33);
        nop(4);

        // In-flight CL3 read survives a switch to CL2.
        mrs(13'h230);
        rd(2'd1, 13'h001, 8'h22);
        mrs(13'h220);
        rd(2'd1, 13'h002, 8'h33);
        nop(5);
        check("cl_switch_err", {28'd0, err}, 32'd0);
        check("cl_switch_q", q.size(), 32'd0);

        // Read to a closed bank: flagged, no data returned.
        issue(C_RD, 2'd2, 13'h005, 1'b0, 8'd0);
        nop(5);
        check("closed_rd_err", {28'd0, err}, 32'd1);

        // Read one cycle after ACT: flagged, but still executes.
        issue(C_ACT, 2'd2, 13'h003, 1'b0, 8'd0);
        nop(2);
        wr(2'd2, 13'h005, 1'b0, 8'h77);
        issue(C_PRE, 2'd2, 13'h000, 1'b0, 8'd0);
        nop(1);
        issue(C_ACT, 2'd2, 13'h003, 1'b0, 8'd0);
        rd(2'd2, 13'h005, 8'h77);
        nop(5);
        check("early_rd_err", {28'd0, err}, 32'd5);

        // ACT to an already open bank.
        issue(C_ACT, 2'd2, 13'h003, 1'b0, 8'd0);
        nop(2);
        check("act_open_err", {28'd0, err}, 32'd7);

        // ACT before the mode load is ignored and flagged.
        do_reset(2);
        issue(C_ACT, 2'd0, 13'h001, 1'b0, 8'd0);
        nop(1);
        check("act_uninit_err", {28'd0, err}, 32'd8);
        check("act_uninit_done", {31'd0, init_done}, 32'd0);

        // Reset one cycle after a READ flushes the return.
        do_reset(2);
        mrs(13'h230);
        issue(C_ACT, 2'd0, 13'h001, 1'b0, 8'd0);
        nop(2);
        issue(C_RD, 2'd0, 13'h000, 1'b0, 8'd0);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nop(1);
            check("flush_oe", {31'd0, dq_oe}, 32'd0);
        end
        rst_n = 1'b1;
        nop(4);
        check("flush_err", {28'd0, err}, 32'd0);
        check("flush_init", {31'd0, init_done}, 32'd0);

        // Any non-NOP inside T_RFC after a REF.
        mrs(13'h230);
        issue(C_REF, 2'd0, 13'h000, 1'b0, 8'd0);
        issue(C_PRE, 2'd0, 13'h400, 1'b0, 8'd0);
        nop(1);
        check("rfc_err", {28'd0, err}, 32'd4);

        nop(4);
        check("sb_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
